// File: rtl/gyro_integrator_if.sv
// Gyro integrator port bundle: frame input from the capture block plus the CPU read port.
interface gyro_integrator_if;
    logic        SAMPLE_ST;
    logic [15:0] GYRO_X;
    logic [15:0] GYRO_Y;
    logic [15:0] GYRO_Z;
    logic        CAL_REQ;
    logic        ZERO;
    logic [3:0]  A;
    logic [31:0] RD;
    logic        READY;

    modport master (
        output SAMPLE_ST, GYRO_X, GYRO_Y, GYRO_Z, CAL_REQ, ZERO, A,
        input  RD, READY
    );

    modport slave (
        input  SAMPLE_ST, GYRO_X, GYRO_Y, GYRO_Z, CAL_REQ, ZERO, A,
        output RD, READY
    );
endinterface

// File: rtl/gyro_integrator.sv
// Gyro bias calibration plus three saturating angle integrators; frame at t is visible on RD at t+2.
// No backpressure: a strobe is accepted every cycle and the two-stage pipeline never stalls.
module gyro_integrator #(
    parameter int CAL_LOG2 = 6,
    parameter int DEADBAND = 4
) (
    input logic              CLK,
    input logic              RESET,
    gyro_integrator_if.slave bus
);
    localparam int SW = 16 + CAL_LOG2;
    localparam logic [0:0] ST_CAL = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;
    localparam logic signed [16:0] DB_HI = 17'(DEADBAND);
    localparam logic signed [16:0] DB_LO = -DB_HI;
    localparam logic signed [31:0] ANG_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] ANG_MIN = 32'sh8000_0000;

    logic [0:0]          state;
    logic                ready;
    logic [CAL_LOG2-1:0] cal_cnt;
    logic                s1_vld;
    logic [31:0]         frame_cnt;

    logic signed [SW-1:0] sum_q    [3];
    logic signed [15:0]   bias_q   [3];
    logic signed [31:0]   angle_q  [3];
    logic signed [16:0]   corr_q   [3];

    logic signed [15:0]   gyro      [3];
    logic signed [SW-1:0] full_sum  [3];
    logic signed [SW-1:0] avg       [3];
    logic signed [16:0]   corr_raw  [3];
    logic signed [16:0]   corr_db   [3];
    logic signed [32:0]   acc       [3];
    logic signed [31:0]   angle_nxt [3];

    logic take_frame;
    logic cal_last;
    logic s1_load;

    assign gyro[0] = bus.GYRO_X;
    assign gyro[1] = bus.GYRO_Y;
    assign gyro[2] = bus.GYRO_Z;

    // A strobe coinciding with CAL_REQ is dropped in both states.
    assign take_frame = bus.SAMPLE_ST && !bus.CAL_REQ;
    assign cal_last   = (state == ST_CAL) && take_frame && (cal_cnt == {CAL_LOG2{1'b1}});
    assign s1_load    = (state == ST_RUN) && take_frame;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            full_sum[i] = sum_q[i] + SW'(gyro[i]);
            avg[i]      = full_sum[i] >>> CAL_LOG2;
            corr_raw[i] = 17'(gyro[i]) - 17'(bias_q[i]);
            corr_db[i]  = (corr_raw[i] >= DB_LO && corr_raw[i] <= DB_HI) ? '0 : corr_raw[i];
            acc[i]      = 33'(angle_q[i]) + 33'(corr_q[i]);
            // Overflow shows up as the two top bits disagreeing; clamp toward the sign of the sum.
            if (acc[i][32] != acc[i][31]) begin
                angle_nxt[i] = acc[i][32] ? ANG_MIN : ANG_MAX;
            end else begin
                angle_nxt[i] = acc[i][31:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_CAL;
            ready     <= 1'b0;
            cal_cnt   <= '0;
            s1_vld    <= 1'b0;
            frame_cnt <= '0;
            for (int i = 0; i < 3; i++) begin
                sum_q[i]   <= '0;
                bias_q[i]  <= '0;
                angle_q[i] <= '0;
                corr_q[i]  <= '0;
            end
        end else begin
            s1_vld <= s1_load;
            if (s1_vld) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
            for (int i = 0; i < 3; i++) begin
                corr_q[i] <= corr_db[i];
                if (bus.ZERO) begin
                    angle_q[i] <= '0;
                end else if (s1_vld) begin
                    angle_q[i] <= angle_nxt[i];
                end
            end

            if (bus.CAL_REQ) begin
                state   <= ST_CAL;
                ready   <= 1'b0;
                cal_cnt <= '0;
                for (int i = 0; i < 3; i++) begin
                    sum_q[i] <= '0;
                end
            end else if (state == ST_CAL && bus.SAMPLE_ST) begin
                if (cal_last) begin
                    state   <= ST_RUN;
                    ready   <= 1'b1;
                    cal_cnt <= '0;
                    for (int i = 0; i < 3; i++) begin
                        bias_q[i] <= avg[i][15:0];
                        sum_q[i]  <= '0;
                    end
                end else begin
                    cal_cnt <= cal_cnt + CAL_LOG2'(1);
                    for (int i = 0; i < 3; i++) begin
                        sum_q[i] <= full_sum[i];
                    end
                end
            end
        end
    end

    always_comb begin
        bus.RD = '0;
        case (bus.A)
            4'd0:    bus.RD = angle_q[0];
            4'd1:    bus.RD = angle_q[1];
            4'd2:    bus.RD = angle_q[2];
            4'd3:    bus.RD = 32'(bias_q[0]);
            4'd4:    bus.RD = 32'(bias_q[1]);
            4'd5:    bus.RD = 32'(bias_q[2]);
            4'd6:    bus.RD = {30'b0, state == ST_CAL, ready};
            4'd7:    bus.RD = frame_cnt;
            default: bus.RD = '0;
        endcase
    end

    assign bus.READY = ready;
endmodule

// File: tb/tb_gyro_integrator.sv
// Randomized and directed bench for gyro_integrator against a cycle-level arithmetic reference model.
module tb_gyro_integrator;
    logic CLK = 1'b0;
    logic RESET;

    gyro_integrator_if bus ();

    gyro_integrator #(.CAL_LOG2(6), .DEADBAND(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: calibration as an integer average, angles as wide integers clamped to 32 bits.
    bit          m_run;
    int          m_cnt;
    longint      m_sum  [3];
    int          m_bias [3];
    longint      m_ang  [3];
    logic [31:0] m_frames;
    bit          p_vld;
    longint      p_corr [3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint floor_div(input longint s, input longint d);
        longint q;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint clamp32(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic logic [31:0] model_rd(input logic [3:0] a);
        case (a)
            4'd0, 4'd1, 4'd2: return 32'(m_ang[a]);
            4'd3, 4'd4, 4'd5: return 32'(m_bias[a - 4'd3]);
            4'd6:             return {30'b0, !m_run, m_run};
            4'd7:             return m_frames;
            default:          return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_cnt = 0;
        m_frames = '0;
        p_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_sum[i] = 0; m_bias[i] = 0; m_ang[i] = 0; p_corr[i] = 0;
        end
    endtask

    task automatic model_edge();
        int     g [3];
        bit     st, cr, zr, nv;
        longint nc [3];
        longint c;
        g[0] = int'($signed(bus.GYRO_X));
        g[1] = int'($signed(bus.GYRO_Y));
        g[2] = int'($signed(bus.GYRO_Z));
        st = bus.SAMPLE_ST; cr = bus.CAL_REQ; zr = bus.ZERO;
        nv = m_run && st && !cr;
        for (int i = 0; i < 3; i++) begin
            c = longint'(g[i]) - longint'(m_bias[i]);
            if (c >= -4 && c <= 4) c = 0;
            nc[i] = c;
        end
        if (p_vld) m_frames = m_frames + 32'd1;
        for (int i = 0; i < 3; i++) begin
            if (zr) m_ang[i] = 0;
            else if (p_vld) m_ang[i] = clamp32(m_ang[i] + p_corr[i]);
        end
        p_vld = nv;
        for (int i = 0; i < 3; i++) p_corr[i] = nc[i];
        if (cr) begin
            m_run = 1'b0; m_cnt = 0;
            for (int i = 0; i < 3; i++) m_sum[i] = 0;
        end else if (!m_run && st) begin
            for (int i = 0; i < 3; i++) m_sum[i] = m_sum[i] + g[i];
            m_cnt++;
            if (m_cnt == 64) begin
                for (int i = 0; i < 3; i++) begin
                    m_bias[i] = int'(floor_div(m_sum[i], 64));
                    m_sum[i] = 0;
                end
                m_run = 1'b1; m_cnt = 0;
            end
        end
    endtask

    always @(posedge CLK) begin
        if (RESET) model_reset();
        else model_edge();
    end

    // One clocked frame slot: check a random register and READY, drive inputs, then idle them.
    task automatic step(input bit st, input int x, input int y, input int z, input bit cr, input bit zr);
        logic [3:0] a;
        @(negedge CLK);
        a = 4'($urandom_range(0, 15));
        bus.A = a;
        #1;
        check_val($sformatf("rd[%0d]", a), bus.RD, model_rd(a));
        check_val("ready", {31'b0, bus.READY}, {31'b0, m_run});
        bus.SAMPLE_ST = st;
        bus.GYRO_X = 16'(x); bus.GYRO_Y = 16'(y); bus.GYRO_Z = 16'(z);
        bus.CAL_REQ = cr; bus.ZERO = zr;
        @(posedge CLK);
        #1;
        bus.SAMPLE_ST = 1'b0; bus.CAL_REQ = 1'b0; bus.ZERO = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        @(negedge CLK);
        bus.A = a;
        #1;
        check_val(tag, bus.RD, exp);
    endtask

    task automatic read_all_model(input string tag);
        for (int a = 0; a < 16; a++) read_chk($sformatf("%s[%0d]", tag, a), 4'(a), model_rd(4'(a)));
    endtask

    function automatic int rnd_gyro();
        if ($urandom_range(0, 3) == 0) return int'($signed(16'($urandom)));
        return int'($urandom_range(0, 40)) - 20;
    endfunction

    initial begin
        RESET = 1'b1;
        bus.SAMPLE_ST = 1'b0; bus.CAL_REQ = 1'b0; bus.ZERO = 1'b0;
        bus.GYRO_X = '0; bus.GYRO_Y = '0; bus.GYRO_Z = '0; bus.A = '0;
        for (int a = 0; a < 16; a++) read_chk($sformatf("reset[%0d]", a), 4'(a), (a == 6) ? 32'd2 : 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int k = 0; k < 64; k++) step(1, 10, -7, 0, 0, 0);
        read_chk("bias_x", 4'd3, 32'd10);
        read_chk("bias_y", 4'd4, 32'hFFFF_FFF9);
        read_chk("bias_z", 4'd5, 32'd0);
        read_chk("status_run", 4'd6, 32'd1);

        for (int k = 1; k <= 3; k++) begin
            step(1, 110, -7, 0, 0, 0);
            read_chk($sformatf("ang_x_pre%0d", k), 4'd0, 32'(100 * (k - 1)));
            read_chk($sformatf("ang_x_post%0d", k), 4'd0, 32'(100 * k));
        end
        read_chk("frames3", 4'd7, 32'd3);

        step(1, 14, -7, 0, 0, 0);
        step(1, 6, -7, 0, 0, 0);
        step(1, 15, -7, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        read_chk("deadband_x", 4'd0, 32'd305);

        step(1, 50, -7, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        read_chk("zero_win_x", 4'd0, 32'd0);
        read_chk("zero_cnt", 4'd7, 32'd7);

        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 1) == 1, rnd_gyro(), rnd_gyro(), rnd_gyro(),
                 $urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0);
        read_all_model("rand_end");

        step(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 32; k++) step(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 32; k++) step(1, 2, 0, 0, 0, 0);
        read_chk("round_pos", 4'd3, 32'd1);
        step(0, 0, 0, 0, 1, 0);
        read_chk("calreq_status", 4'd6, 32'd2);
        for (int k = 0; k < 64; k++) step(1, -1, 0, 0, 0, 0);
        read_chk("round_neg", 4'd3, 32'hFFFF_FFFF);
        read_all_model("after_recal");

        step(0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 64; k++) step(1, -32768, 32767, 0, 0, 0);
        for (int k = 0; k < 32770; k++) step(1, 32767, -32768, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        read_chk("sat_hi", 4'd0, 32'h7FFF_FFFF);
        read_chk("sat_lo", 4'd1, 32'h8000_0000);
        step(0, 0, 0, 0, 1, 0);
        read_chk("hold_hi", 4'd0, 32'h7FFF_FFFF);
        for (int k = 0; k < 64; k++) step(1, 0, 0, 0, 0, 0);
        step(1, -100, 100, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        read_chk("unsat_hi", 4'd0, 32'h7FFF_FF9B);
        read_chk("unsat_lo", 4'd1, 32'h8000_0064);

        step(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 20; k++) step(1, 5, 5, 5, 0, 0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        for (int a = 0; a < 16; a++) read_chk($sformatf("midrst[%0d]", a), 4'(a), (a == 6) ? 32'd2 : 32'd0);
        for (int k = 0; k < 63; k++) step(1, 3, 3, 3, 0, 0);
        read_chk("recal_63", 4'd6, 32'd2);
        step(1, 3, 3, 3, 0, 0);
        read_chk("recal_64", 4'd6, 32'd1);
        read_chk("recal_bias", 4'd3, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
